game_pacman: RTL and testbench

- Pac-Man movement controller. It sits directly upstream of the maze and ghost blocks.
- Converts joystick requests plus maze wall information into Pac-Man's pixel position, facing direction and tile coordinates.
- Its outputs drive the maze's pacman tile query and the ghosts' Pac-Man input bus.
- Handles buffered turns, reversals, tunnel wrap, step pacing and death/respawn.

---
 rtl/game_pacman.sv | 236 +++++++++++++++++++++++
 tb/tb_game_pacman.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_pacman.sv
// Pac-Man movement controller: joystick + wall flags -> pixel position, facing, tile coordinates.
// Latency: position/dir update one clk after a step tick; every output is a register or a slice of one.
// Backpressure: none; walls hold Pac-Man in place, the pellet stall (PACMAN_EAT_STALL_EN) eats one tick.
//
// Ports:
//   clk, rst            game clock, synchronous active-high reset
//   start               level; IDLE -> RUN while high
//   joy[3:0]            {up,left,down,right} requests, 1 = pressed
//   tile_info[3:0]      {up,left,down,right} wall flags around the current tile
//   pellet, caught      pellet-eaten pulse, ghost collision pulse
//   pacman_x/y/dir      pixel position and facing (0 right, 1 up, 2 left, 3 down)
//   pacman_tiles        {x>>3, (y>>3)-3} for the maze tile query
//   pacman_outputs      {x, y, dir, state} bus for the ghosts
//   moving              last step tick moved a pixel
// Optional feature macro: PACMAN_EAT_STALL_EN (pellet makes the next step tick a no-move).

module game_pacman #(
    parameter int START_X      = 119,
    parameter int START_Y      = 227,
    parameter int STEP_DIV     = 4,
    parameter int CENTER_OFS   = 3,
    parameter int MAZE_W_PX    = 224,
    parameter int TUNNEL_ROW   = 14,
    parameter int DEATH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  joy,
    input  logic [3:0]  tile_info,
    input  logic        pellet,
    input  logic        caught,
    output logic [9:0]  pacman_x,
    output logic [9:0]  pacman_y,
    output logic [1:0]  pacman_dir,
    output logic [13:0] pacman_tiles,
    output logic [24:0] pacman_outputs,
    output logic        moving
);

    localparam int SCNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int DCNT_W = (DEATH_CYCLES > 2) ? $clog2(DEATH_CYCLES) : 1;

    localparam logic [SCNT_W-1:0] STEP_LAST  = SCNT_W'(STEP_DIV - 1);
    localparam logic [DCNT_W-1:0] DEATH_LAST = DCNT_W'(DEATH_CYCLES - 1);
    localparam logic [9:0]        X_START    = 10'(START_X);
    localparam logic [9:0]        Y_START    = 10'(START_Y);
    localparam logic [9:0]        X_WRAP_MAX = 10'(MAZE_W_PX - 1);
    localparam logic [2:0]        CENTER     = 3'(CENTER_OFS);
    localparam logic [6:0]        T_ROW      = 7'(TUNNEL_ROW);

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [1:0]        dir_q, dir_d;
    logic [1:0]        req_q, req_d;
    logic              moving_q, moving_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              stall_q, stall_d;

    logic       tick;
    logic       centred;
    logic [6:0] y_row;
    logic       in_tunnel;
    logic       go;
    logic [1:0] go_dir;
    logic [9:0] nx, ny;
    logic       joy_any;
    logic [1:0] joy_dir;

    // Wall flags are ordered {up,left,down,right}, which does not follow the
    // dir encoding, so look the bit up by direction name.
    function automatic logic wall_of(input logic [3:0] ti, input logic [1:0] d);
        case (d)
            DIR_RIGHT: wall_of = ti[0];
            DIR_UP:    wall_of = ti[3];
            DIR_LEFT:  wall_of = ti[2];
            default:   wall_of = ti[1];
        endcase
    endfunction

    assign tick      = (scnt_q == STEP_LAST);
    assign centred   = (x_q[2:0] == CENTER) && (y_q[2:0] == CENTER);
    assign y_row     = y_q[9:3] - 7'd3;
    assign in_tunnel = (y_row == T_ROW);
    assign joy_any   = |joy;

    // Priority up > left > down > right.
    always_comb begin
        joy_dir = req_q;
        if (joy[3])      joy_dir = DIR_UP;
        else if (joy[2]) joy_dir = DIR_LEFT;
        else if (joy[1]) joy_dir = DIR_DOWN;
        else if (joy[0]) joy_dir = DIR_RIGHT;
    end

    // Step decision: reversal anywhere, turns only at tile centre,
    // otherwise keep going in the current direction.
    always_comb begin
        go     = 1'b1;
        go_dir = dir_q;
        if (req_q == (dir_q ^ 2'd2)) begin
            go_dir = req_q;
        end else if (centred) begin
            if ((req_q != dir_q) && !wall_of(tile_info, req_q)) begin
                go_dir = req_q;
            end else if (wall_of(tile_info, dir_q)) begin
                go = 1'b0;
            end
        end
    end

    // Candidate position one pixel along go_dir, with tunnel wrap.
    always_comb begin
        nx = x_q;
        ny = y_q;
        case (go_dir)
            DIR_RIGHT: nx = (in_tunnel && x_q == X_WRAP_MAX) ? 10'd0 : x_q + 10'd1;
            DIR_LEFT:  nx = (in_tunnel && x_q == 10'd0) ? X_WRAP_MAX : x_q - 10'd1;
            DIR_UP:    ny = y_q - 10'd1;
            default:   ny = y_q + 10'd1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        req_d    = req_q;
        moving_d = moving_q;
        scnt_d   = scnt_q;
        dcnt_d   = dcnt_q;
        stall_d  = stall_q;
        case (state_q)
            ST_IDLE: begin
                moving_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    scnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (caught) begin
                    state_d  = ST_DEAD;
                    moving_d = 1'b0;
                    scnt_d   = '0;
                    dcnt_d   = '0;
                    stall_d  = 1'b0;
                end else begin
                    if (joy_any) req_d = joy_dir;
                    scnt_d = tick ? '0 : scnt_q + 1'b1;
                    if (tick) begin
                        if (stall_q || !go) begin
                            moving_d = 1'b0;
                        end else begin
                            x_d      = nx;
                            y_d      = ny;
                            dir_d    = go_dir;
                            moving_d = 1'b1;
                        end
                    end
`ifdef PACMAN_EAT_STALL_EN
                    // A set flag is spent by the next tick; pellets while set do not stack.
                    if (tick && stall_q) stall_d = 1'b0;
                    else if (pellet)     stall_d = 1'b1;
`else
                    stall_d = 1'b0;
`endif
                end
            end
            default: begin
                moving_d = 1'b0;
                if (dcnt_q == DEATH_LAST) begin
                    state_d = ST_IDLE;
                    x_d     = X_START;
                    y_d     = Y_START;
                    dir_d   = DIR_LEFT;
                    req_d   = DIR_LEFT;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        endcase
    end

`ifndef PACMAN_EAT_STALL_EN
    logic unused_pellet;
    assign unused_pellet = pellet;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= X_START;
            y_q      <= Y_START;
            dir_q    <= DIR_LEFT;
            req_q    <= DIR_LEFT;
            moving_q <= 1'b0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            req_q    <= req_d;
            moving_q <= moving_d;
            scnt_q   <= scnt_d;
            dcnt_q   <= dcnt_d;
            stall_q  <= stall_d;
        end
    end

    assign pacman_x       = x_q;
    assign pacman_y       = y_q;
    assign pacman_dir     = dir_q;
    assign pacman_tiles   = {x_q[9:3], y_row};
    assign pacman_outputs = {x_q, y_q, dir_q, {1'b0, state_q}};
    assign moving         = moving_q;

endmodule

// File: tb/tb_game_pacman.sv
// Bench for game_pacman: directed scenarios plus randomized run against a behavioural model.
// Three instances share stimulus: default start, tunnel-row start (1,139), non-tunnel row start (1,131).
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.

module tb_game_pacman;

    localparam int STEP_DIV     = 4;
    localparam int DEATH_CYCLES = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] joy = 4'd0;
    logic [3:0] tile_info = 4'd0;
    logic       pellet = 1'b0;
    logic       caught = 1'b0;

    logic [9:0]  px [3];
    logic [9:0]  py [3];
    logic [1:0]  pd [3];
    logic [13:0] pt [3];
    logic [24:0] po [3];
    logic        mv [3];

    game_pacman u0 (
        .clk(clk), .rst(rst), .start(start), .joy(joy), .tile_info(tile_info),
        .pellet(pellet), .caught(caught), .pacman_x(px[0]), .pacman_y(py[0]),
        .pacman_dir(pd[0]), .pacman_tiles(pt[0]), .pacman_outputs(po[0]), .moving(mv[0])
    );
    game_pacman #(.START_X(1), .START_Y(139)) u1 (
        .clk(clk), .rst(rst), .start(start), .joy(joy), .tile_info(tile_info),
        .pellet(pellet), .caught(caught), .pacman_x(px[1]), .pacman_y(py[1]),
        .pacman_dir(pd[1]), .pacman_tiles(pt[1]), .pacman_outputs(po[1]), .moving(mv[1])
    );
    game_pacman #(.START_X(1), .START_Y(131)) u2 (
        .clk(clk), .rst(rst), .start(start), .joy(joy), .tile_info(tile_info),
        .pellet(pellet), .caught(caught), .pacman_x(px[2]), .pacman_y(py[2]),
        .pacman_dir(pd[2]), .pacman_tiles(pt[2]), .pacman_outputs(po[2]), .moving(mv[2])
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one slot per instance.
    int SX [3] = '{119, 1, 1};
    int SY [3] = '{227, 139, 131};
    int DX [4] = '{1, 0, -1, 0};   // right, up, left, down
    int DY [4] = '{0, -1, 0, 1};
    int m_x [3], m_y [3], m_dir [3], m_req [3], m_st [3], m_mov [3];
    int m_scnt [3], m_dcnt [3], m_stall [3];

    function automatic int blocked(int d);
        // wall flags arrive as {up,left,down,right}
        case (d)
            0:       return int'(tile_info[0]);
            1:       return int'(tile_info[3]);
            2:       return int'(tile_info[2]);
            default: return int'(tile_info[1]);
        endcase
    endfunction

    task automatic model_move(int i);
        int r, d, nd, go, nx, ny, row, centred;
        r = m_req[i];
        d = m_dir[i];
        centred = (m_x[i] % 8 == 3) && (m_y[i] % 8 == 3);
        go = 1;
        nd = d;
        if (r == (d + 2) % 4) nd = r;
        else if (centred) begin
            if (r != d && blocked(r) == 0) nd = r;
            else if (blocked(d) != 0) go = 0;
        end
        if (go == 0) begin
            m_mov[i] = 0;
        end else begin
            nx  = m_x[i] + DX[nd];
            ny  = m_y[i] + DY[nd];
            row = ((m_y[i] / 8) - 3) & 127;
            if (row == 14 && nd == 2 && m_x[i] == 0)   nx = 223;
            if (row == 14 && nd == 0 && m_x[i] == 223) nx = 0;
            m_x[i]   = nx & 1023;
            m_y[i]   = ny & 1023;
            m_dir[i] = nd;
            m_mov[i] = 1;
        end
    endtask

    task automatic model_update();
        int tick;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_x[i] = SX[i]; m_y[i] = SY[i]; m_dir[i] = 2; m_req[i] = 2;
                m_st[i] = 0; m_mov[i] = 0; m_scnt[i] = 0; m_dcnt[i] = 0; m_stall[i] = 0;
            end else if (m_st[i] == 0) begin
                m_mov[i] = 0;
                if (start) begin m_st[i] = 1; m_scnt[i] = 0; end
            end else if (m_st[i] == 1) begin
                if (caught) begin
                    m_st[i] = 2; m_mov[i] = 0; m_scnt[i] = 0; m_dcnt[i] = 0; m_stall[i] = 0;
                end else begin
                    tick = (m_scnt[i] == STEP_DIV - 1) ? 1 : 0;
                    m_scnt[i] = (tick != 0) ? 0 : m_scnt[i] + 1;
                    if (tick != 0) begin
                        if (m_stall[i] != 0) m_mov[i] = 0;
                        else model_move(i);
                    end
`ifdef PACMAN_EAT_STALL_EN
                    if (tick != 0 && m_stall[i] != 0) m_stall[i] = 0;
                    else if (pellet) m_stall[i] = 1;
`endif
                    if (joy[3])      m_req[i] = 1;
                    else if (joy[2]) m_req[i] = 2;
                    else if (joy[1]) m_req[i] = 3;
                    else if (joy[0]) m_req[i] = 0;
                end
            end else begin
                m_mov[i] = 0;
                if (m_dcnt[i] == DEATH_CYCLES - 1) begin
                    m_st[i] = 0; m_x[i] = SX[i]; m_y[i] = SY[i]; m_dir[i] = 2; m_req[i] = 2;
                    m_dcnt[i] = 0;
                end else begin
                    m_dcnt[i] = m_dcnt[i] + 1;
                end
            end
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; joy = 4'd0; caught = 1'b0; pellet = 1'b0; tile_info = 4'd0;
        clk_cycle();
        clk_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] exp_t;
        logic [24:0] exp_o;
        exp_t = {7'd14, 7'd25};
        exp_o = {10'd119, 10'd227, 2'd2, 3'd0};
        rst = 1'b1;
        clk_cycle();
        clk_cycle();
        total++; if (px[0] !== 10'd119) begin bad++; $display("FAIL reset_x got %0d want 119", px[0]); end
        total++; if (py[0] !== 10'd227) begin bad++; $display("FAIL reset_y got %0d want 227", py[0]); end
        total++; if (pd[0] !== 2'd2)    begin bad++; $display("FAIL reset_dir got %0d want 2", pd[0]); end
        total++; if (mv[0] !== 1'b0)    begin bad++; $display("FAIL reset_moving got %b want 0", mv[0]); end
        total++; if (pt[0] !== exp_t)   begin bad++; $display("FAIL reset_tiles got %h want %h", pt[0], exp_t); end
        total++; if (po[0] !== exp_o)   begin bad++; $display("FAIL reset_outputs got %h want %h", po[0], exp_o); end
        total++; if (pt[1] !== 14'd14)  begin bad++; $display("FAIL reset_tiles_u1 got %h want %h", pt[1], 14'd14); end
        rst = 1'b0;
    endtask

    // Walk left from 119 to 115, then stop against a wall, then turn up.
    task automatic test_walk_wall_turn();
        do_reset();
        start = 1'b1;
        clk_cycle();
        total++; if (po[0][2:0] !== 3'd1) begin bad++; $display("FAIL run_state got %0d want 1", po[0][2:0]); end
        for (int k = 1; k <= 4; k++) begin
            repeat (STEP_DIV) clk_cycle();
            total++;
            if (px[0] !== 10'(119 - k) || py[0] !== 10'd227 || mv[0] !== 1'b1) begin
                bad++;
                $display("FAIL walk_step%0d got x=%0d y=%0d mv=%b want x=%0d y=227 mv=1", k, px[0], py[0], mv[0], 119 - k);
            end
        end
        tile_info = 4'b0100;
        repeat (2 * STEP_DIV) clk_cycle();
        total++;
        if (px[0] !== 10'd115 || mv[0] !== 1'b0) begin
            bad++; $display("FAIL wall_hold got x=%0d mv=%b want x=115 mv=0", px[0], mv[0]);
        end
        joy = 4'b1000;
        clk_cycle();
        joy = 4'd0;
        repeat (STEP_DIV) clk_cycle();
        total++;
        if (pd[0] !== 2'd1 || py[0] !== 10'd226 || px[0] !== 10'd115 || mv[0] !== 1'b1) begin
            bad++; $display("FAIL turn_up got dir=%0d x=%0d y=%0d mv=%b want dir=1 x=115 y=226 mv=1", pd[0], px[0], py[0], mv[0]);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        start = 1'b1;
        clk_cycle();
        repeat (2 * STEP_DIV) clk_cycle();
        total++; if (px[0] !== 10'd117) begin bad++; $display("FAIL rev_setup got x=%0d want 117", px[0]); end
        joy = 4'b0001;
        clk_cycle();
        joy = 4'd0;
        repeat (STEP_DIV) clk_cycle();
        total++;
        if (pd[0] !== 2'd0 || px[0] !== 10'd118) begin
            bad++; $display("FAIL reversal got dir=%0d x=%0d want dir=0 x=118", pd[0], px[0]);
        end
        repeat (STEP_DIV) clk_cycle();
        total++; if (px[0] !== 10'd119) begin bad++; $display("FAIL rev_continue got x=%0d want 119", px[0]); end
    endtask

    task automatic test_tunnel();
        int exp1 [3] = '{0, 223, 222};
        int exp2 [3] = '{0, 1023, 1022};
        do_reset();
        start = 1'b1;
        clk_cycle();
        for (int k = 0; k < 3; k++) begin
            repeat (STEP_DIV) clk_cycle();
            total++;
            if (px[1] !== 10'(exp1[k]) || py[1] !== 10'd139) begin
                bad++; $display("FAIL tunnel_wrap%0d got x=%0d y=%0d want x=%0d y=139", k, px[1], py[1], exp1[k]);
            end
            total++;
            if (px[2] !== 10'(exp2[k])) begin
                bad++; $display("FAIL no_wrap%0d got x=%0d want %0d", k, px[2], exp2[k]);
            end
        end
    endtask

    task automatic test_caught();
        do_reset();
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        repeat (5) clk_cycle();
        caught = 1'b1;
        clk_cycle();
        caught = 1'b0;
        total++;
        if (po[0][2:0] !== 3'd2 || mv[0] !== 1'b0) begin
            bad++; $display("FAIL dead_enter got state=%0d mv=%b want 2 0", po[0][2:0], mv[0]);
        end
        for (int k = 1; k < DEATH_CYCLES; k++) begin
            clk_cycle();
            total++;
            if (po[0][2:0] !== 3'd2) begin
                bad++; $display("FAIL dead_hold%0d got state=%0d want 2", k, po[0][2:0]);
            end
        end
        clk_cycle();
        total++;
        if (po[0] !== {10'd119, 10'd227, 2'd2, 3'd0}) begin
            bad++; $display("FAIL respawn got outputs=%h want %h", po[0], {10'd119, 10'd227, 2'd2, 3'd0});
        end
        caught = 1'b1;
        clk_cycle();
        caught = 1'b0;
        total++;
        if (po[0][2:0] !== 3'd0) begin bad++; $display("FAIL caught_idle got state=%0d want 0", po[0][2:0]); end
    endtask

    task automatic test_pellet();
        int exp_a, exp_b, exp_ma;
`ifdef PACMAN_EAT_STALL_EN
        exp_a = 119; exp_ma = 0; exp_b = 118;
`else
        exp_a = 118; exp_ma = 1; exp_b = 117;
`endif
        do_reset();
        start = 1'b1;
        clk_cycle();
        pellet = 1'b1;
        clk_cycle();
        pellet = 1'b0;
        repeat (STEP_DIV - 1) clk_cycle();
        total++;
        if (px[0] !== 10'(exp_a) || mv[0] !== 1'(exp_ma)) begin
            bad++; $display("FAIL pellet_tick1 got x=%0d mv=%b want x=%0d mv=%0d", px[0], mv[0], exp_a, exp_ma);
        end
        repeat (STEP_DIV) clk_cycle();
        total++;
        if (px[0] !== 10'(exp_b) || mv[0] !== 1'b1) begin
            bad++; $display("FAIL pellet_tick2 got x=%0d mv=%b want x=%0d mv=1", px[0], mv[0], exp_b);
        end
    endtask

    task automatic test_random();
        logic [24:0] eo;
        logic [13:0] et;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            joy       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            tile_info = 4'($urandom);
            caught    = ($urandom_range(0, 80) == 0);
            pellet    = ($urandom_range(0, 8) == 0);
            start     = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 900) == 0);
            clk_cycle();
            for (int i = 0; i < 3; i++) begin
                eo = {10'(m_x[i]), 10'(m_y[i]), 2'(m_dir[i]), 3'(m_st[i])};
                et = {7'(m_x[i] >> 3), 7'((m_y[i] >> 3) - 3)};
                total++;
                if (po[i] !== eo || pt[i] !== et || mv[i] !== 1'(m_mov[i])) begin
                    bad++;
                    $display("FAIL random u%0d cyc%0d got out=%h tiles=%h mv=%b want out=%h tiles=%h mv=%0d",
                             i, c, po[i], pt[i], mv[i], eo, et, m_mov[i]);
                end
            end
        end
        rst = 1'b0; caught = 1'b0; pellet = 1'b0; joy = 4'd0;
    endtask

    initial begin
        test_reset();
        test_walk_wall_turn();
        test_reversal();
        test_tunnel();
        test_caught();
        test_pellet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
